// File: rtl/button_event_frontend.sv
// Button conditioner: sync, debounce, press pulses and a small event FIFO
// feeding the game core over a valid/ready handshake.
module button_event_frontend #(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int FIFO_DEPTH      = 4,
  parameter int IDX_W           = 3
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [NUM_BTN-1:0]                 btn_n,
  output logic [NUM_BTN-1:0]                 btn_level,
  output logic [NUM_BTN-1:0]                 press_pulse,
  output logic                               evt_valid,
  output logic [IDX_W-1:0]                   evt_idx,
  input  logic                               evt_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               evt_overflow,
  input  logic                               overflow_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES-1);

  logic [NUM_BTN-1:0] sync1, sync2, s;
  logic [NUM_BTN-1:0] level_q, accept;
  logic [CNT_W-1:0]   cnt [NUM_BTN];
  logic [NUM_BTN-1:0] pending;
  logic [IDX_W-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]      rd, wr;
  logic [IDX_W-1:0]   idx_last;

  logic [NUM_BTN-1:0] cand, push_oh, push_sel;
  logic [IDX_W-1:0]   push_idx;
  logic               pop, push, space, ovf_set;

  assign s         = ~sync2;
  assign btn_level = level_q;

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++)
      accept[i] = (s[i] != level_q[i]) && (cnt[i] == LAST);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1       <= '1;
      sync2       <= '1;
      level_q     <= '0;
      press_pulse <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
    end else begin
      sync1       <= btn_n;
      sync2       <= sync1;
      press_pulse <= accept & s;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (s[i] == level_q[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          level_q[i] <= s[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Lowest pending/new press wins; the rest wait in pending.
  always_comb begin
    cand     = pending | press_pulse;
    pop      = evt_valid & evt_ready;
    space    = (fifo_count < CW'(FIFO_DEPTH)) | pop;
    push     = space & (|cand);
    push_oh  = cand & (~cand + 1'b1);
    push_sel = push ? push_oh : '0;
    ovf_set  = |(press_pulse & pending & ~push_sel);
    push_idx = '0;
    for (int i = 0; i < NUM_BTN; i++)
      if (push_oh[i]) push_idx = IDX_W'(i);
  end

  assign evt_valid = (fifo_count != '0);
  assign evt_idx   = evt_valid ? mem[rd] : idx_last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending      <= '0;
      evt_overflow <= 1'b0;
      rd           <= '0;
      wr           <= '0;
      fifo_count   <= '0;
      idx_last     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      pending  <= cand & ~push_sel;
      idx_last <= evt_idx;
      if (ovf_set)
        evt_overflow <= 1'b1;
      else if (overflow_clr)
        evt_overflow <= 1'b0;
      if (push) begin
        mem[wr] <= push_idx;
        wr      <= wr + 1'b1;
      end
      if (pop)
        rd <= rd + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_frontend.sv
// Directed bench for button_event_frontend with a short debounce window.
module tb_button_event_frontend;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] btn_n;
  logic [4:0] btn_level, press_pulse;
  logic       evt_valid;
  logic [2:0] evt_idx;
  logic       evt_ready;
  logic [2:0] fifo_count;
  logic       evt_overflow;
  logic       overflow_clr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  button_event_frontend #(
    .NUM_BTN(5), .DEBOUNCE_CYCLES(4), .CNT_W(20),
    .FIFO_DEPTH(4), .IDX_W(3)
  ) dut (
    .clk(clk), .resetn(resetn), .btn_n(btn_n),
    .btn_level(btn_level), .press_pulse(press_pulse),
    .evt_valid(evt_valid), .evt_idx(evt_idx),
    .evt_ready(evt_ready), .fifo_count(fifo_count),
    .evt_overflow(evt_overflow), .overflow_clr(overflow_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int          seq_idx [$];
  int          seq_cyc [$];
  logic [31:0] acc;
  int          np, nv, vidx;

  initial begin
    resetn       = 1'b0;
    btn_n        = 5'b11110;
    evt_ready    = 1'b0;
    overflow_clr = 1'b0;
    steps(3);
    chk("rst_level", btn_level, 0);
    chk("rst_pulse", press_pulse, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_idx", evt_idx, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", evt_overflow, 0);

    // first press after reset release: 2 sync + 4 debounce cycles
    resetn = 1'b1;
    steps(5);
    chk("lat5_level", btn_level[0], 0);
    step();
    chk("lat6_level", btn_level[0], 1);
    chk("lat6_pulse", press_pulse, 5'b00001);
    chk("lat6_valid", evt_valid, 0);
    step();
    chk("lat7_pulse", press_pulse, 0);
    chk("lat7_valid", evt_valid, 1);
    chk("lat7_idx", evt_idx, 0);
    chk("lat7_count", fifo_count, 1);
    evt_ready = 1'b1;
    step();
    chk("pop_count", fifo_count, 0);
    chk("hold_idx", evt_idx, 0);
    btn_n = 5'b11111;
    steps(8);
    chk("rel0_level", btn_level, 0);

    // bounce on ch1: 3 low, 1 high, 3 low
    acc = 0;
    btn_n[1] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 3) btn_n[1] = 1'b1;
      if (k == 4) btn_n[1] = 1'b0;
      if (k == 7) btn_n[1] = 1'b1;
      step();
      acc = acc | {btn_level[1], press_pulse[1], evt_valid};
    end
    chk("bounce_activity", acc, 0);
    chk("bounce_count", fifo_count, 0);

    // single press on ch2 with consumer ready
    np = 0; nv = 0; vidx = 7;
    btn_n[2] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (press_pulse[2]) np++;
      if (evt_valid) begin nv++; vidx = evt_idx; end
    end
    chk("single_pulses", np, 1);
    chk("single_valid", nv, 1);
    chk("single_idx", vidx, 2);
    chk("single_count", fifo_count, 0);
    np = 0; nv = 0;
    btn_n[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (press_pulse != 0) np++;
      if (evt_valid) nv++;
    end
    chk("release_pulses", np, 0);
    chk("release_valid", nv, 0);
    chk("release_level", btn_level, 0);

    // simultaneous 0,3,4
    btn_n = 5'b00110;
    for (int k = 0; k < 14; k++) begin
      step();
      if (evt_valid) begin
        seq_idx.push_back(int'(evt_idx));
        seq_cyc.push_back(k);
      end
    end
    chk("simul_n", seq_idx.size(), 3);
    if (seq_idx.size() == 3) begin
      chk("simul_e0", seq_idx[0], 0);
      chk("simul_e1", seq_idx[1], 3);
      chk("simul_e2", seq_idx[2], 4);
      chk("simul_span", seq_cyc[2] - seq_cyc[0], 2);
    end
    chk("simul_ovf", evt_overflow, 0);
    btn_n = 5'b11111;
    steps(8);

    // fill FIFO with all five, ch4 left pending
    evt_ready = 1'b0;
    btn_n     = 5'b00000;
    steps(14);
    chk("full_count", fifo_count, 4);
    chk("full_idx", evt_idx, 0);
    chk("full_pending", dut.pending, 5'b10000);
    chk("full_ovf", evt_overflow, 0);
    btn_n[4] = 1'b1;
    steps(8);
    chk("full_ovf_rel", evt_overflow, 0);
    btn_n[4] = 1'b0;
    steps(8);
    chk("ovf_set", evt_overflow, 1);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("ovf_clr", evt_overflow, 0);
    seq_idx.delete();
    evt_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (evt_valid) seq_idx.push_back(int'(evt_idx));
      step();
    end
    chk("drain_n", seq_idx.size(), 5);
    if (seq_idx.size() == 5)
      for (int k = 0; k < 5; k++)
        chk($sformatf("drain_e%0d", k), seq_idx[k], k);
    chk("drain_count", fifo_count, 0);
    btn_n = 5'b11111;
    steps(8);

    // reset in the middle of activity
    evt_ready = 1'b0;
    btn_n     = 5'b11000;
    steps(12);
    chk("mid_count3", fifo_count, 3);
    btn_n[3] = 1'b0;
    steps(4);
    chk("mid_cnt2", dut.cnt[3], 2);
    resetn = 1'b0;
    #2;
    chk("mid_valid", evt_valid, 0);
    chk("mid_count", fifo_count, 0);
    chk("mid_level", btn_level, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    steps(5);
    chk("mid_lat5", btn_level, 0);
    step();
    chk("mid_lat6", btn_level, 5'b01111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_event_frontend.md
Name: button_event_frontend

Overview:
- Input-side conditioner for the whack-a-mole game core. It is the producer side of the button interface that the core consumes.
- Takes raw active-low push-buttons, synchronises and debounces each one, and emits one-cycle press pulses.
- Queues press events, encoded as button indices, into a small FIFO. The game core drains the FIFO with a valid/ready handshake.
- Sits between the board pins and the game/score logic; one instance covers the four mole buttons plus the start button.

Parameters:
- NUM_BTN, 5: number of button channels (index 4 = start).
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronised samples needed to accept a level change (10 ms at 100 MHz).
- CNT_W, 20: debounce counter width; must hold DEBOUNCE_CYCLES-1.
- FIFO_DEPTH, 4: event FIFO entries (power of two).
- IDX_W, 3: event index width; must hold NUM_BTN-1.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- btn_n  in  NUM_BTN  raw buttons, 0 = pressed, asynchronous to clk.
- btn_level  out  NUM_BTN  debounced level, 1 = pressed.
- press_pulse  out  NUM_BTN  one-cycle pulse per accepted press.
- evt_valid  out  1  FIFO head valid.
- evt_idx  out  IDX_W  button index at FIFO head.
- evt_ready  in  1  consumer accepts head this cycle.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied entries.
- evt_overflow  out  1  sticky: a press was dropped.
- overflow_clr  in  1  clears evt_overflow.

Behaviour:
- Reset, async on resetn low:
  - Sync flops = 1 (released); debounce states 0; counters 0.
  - btn_level = 0, press_pulse = 0, pending = 0.
  - FIFO empty: evt_valid = 0, evt_idx = 0, fifo_count = 0; evt_overflow = 0.
  - Applies immediately and discards any in-flight debounce, pending or queued events.
- Synchroniser, per channel:
  - Two-flop synchroniser on btn_n; s = inverted second flop (1 = pressed).
- Debounce, per channel:
  - state holds the accepted level and drives btn_level.
  - If s == state: counter <= 0.
  - Else, if counter == DEBOUNCE_CYCLES-1: state <= s, counter <= 0. Otherwise counter <= counter+1.
  - A change is therefore accepted after exactly DEBOUNCE_CYCLES consecutive differing samples.
  - Latency from raw edge to btn_level = 2 + DEBOUNCE_CYCLES cycles. Any glitch shorter than DEBOUNCE_CYCLES samples resets the counter and is ignored.
- press_pulse[i]:
  - High for exactly the one cycle in which btn_level[i] is first 1 (registered alongside the state flip).
  - Releases generate no pulse and no event.
- Event arbitration, each cycle:
  - cand = pending | press_pulse.
  - space = (fifo_count < FIFO_DEPTH) OR pop this cycle.
  - If cand != 0 and space: push the lowest-index set bit of cand. All other cand bits go to pending.
  - If there is no space: pending <= cand.
  - Exactly one push per cycle at most.
- Overflow:
  - evt_overflow <= 1 when press_pulse[i] is high while pending[i] is already 1 and i is not the index pushed this cycle; that press is dropped.
  - overflow_clr clears evt_overflow; if set and clear occur in the same cycle, set wins.
- FIFO, show-ahead:
  - evt_valid = (fifo_count != 0); evt_idx = head entry.
  - Pop when evt_valid && evt_ready.
  - Simultaneous push and pop when full is allowed; count is unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push into an empty FIFO makes evt_valid high in the next cycle.
- Ordering:
  - Events leave in push order.
  - Simultaneous presses are pushed in ascending index order on consecutive cycles, space permitting.
- evt_idx holds its last value when the FIFO is empty.

Test Plan (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4):
- Reset: hold resetn=0 with btn_n=5'b11110 → all outputs 0. Release reset, keep btn_n[0]=0 → btn_level[0]=1 and press_pulse[0]=1 exactly 6 cycles later; evt_valid next cycle with evt_idx=0.
- Bounce: btn_n[1] low 3 cycles, high 1, low 3 → btn_level[1] stays 0; no pulse, no event, fifo_count=0.
- Single press: btn_n[2] low steady, evt_ready=1 → one press_pulse[2] cycle, evt_valid high one cycle with evt_idx=2, fifo_count returns to 0. Release → no event.
- Simultaneous press: channels 0, 3, 4 pressed in the same cycle, evt_ready=1 → events 0, 3, 4 on three consecutive cycles; evt_overflow=0.
- Full FIFO: evt_ready=0, all 5 channels pressed together → fifo_count=4 (0,1,2,3), pending[4]=1, no overflow. Release and re-press ch4 → evt_overflow=1. Pulse overflow_clr → 0. Set evt_ready=1 → drains 0,1,2,3,4.
- Mid-operation reset: pull resetn low with 3 queued events and a debounce counter at 2 → evt_valid=0 and fifo_count=0 immediately; after release, a held button needs the full 6 cycles again.
